// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared constants and helpers for sync_fifo_flex
package sync_fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // Address bits needed to index a DEPTH-entry memory.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - single-clock storage, registered write, combinational read
module sync_fifo_ram #(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 8,
    parameter int AW        = 3
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [DATAWIDTH-1:0] rdata
);

    logic [DATAWIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - single-clock FIFO with occupancy count, thresholds,
// optional first-word-fall-through, flush and sticky error flags
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 8,
    parameter int FWFT      = FWFT_OFF,
    parameter int AF_LEVEL  = DEPTH - 1,
    parameter int AE_LEVEL  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   clr_err,
    input  logic                   wr,
    input  logic [DATAWIDTH-1:0]   wdata,
    input  logic                   rd,
    output logic [DATAWIDTH-1:0]   rdata,
    output logic                   rvalid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW:0] L_DEPTH = (PW+1)'(DEPTH);
    localparam logic [PW:0] L_AF    = (PW+1)'(AF_LEVEL);
    localparam logic [PW:0] L_AE    = (PW+1)'(AE_LEVEL);
    localparam logic [PW:0] L_ONE   = {{PW{1'b0}}, 1'b1};

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (AF_LEVEL < 1) || (AF_LEVEL > DEPTH) ||
        (AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_params
        $error("sync_fifo_flex: illegal DEPTH, AF_LEVEL or AE_LEVEL");
    end

    logic [PW:0]          r_wptr;
    logic [PW:0]          r_rptr;
    logic [PW:0]          r_count;
    logic [DATAWIDTH-1:0] r_rdata;
    logic                 r_rvalid;
    logic                 r_overflow;
    logic                 r_underflow;

    logic [DATAWIDTH-1:0] w_ram_rdata;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_op_en;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic                 w_ovf_evt;
    logic                 w_unf_evt;

    // Flags come from the registered count, so acceptance uses start-of-cycle state.
    assign w_full    = (r_count == L_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_op_en   = !rst && !flush;
    assign w_wr_acc  = w_op_en && wr && !w_full;
    assign w_rd_acc  = w_op_en && rd && !w_empty;
    assign w_ovf_evt = w_op_en && wr && w_full;
    assign w_unf_evt = w_op_en && rd && w_empty;

    sync_fifo_ram #(
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (DEPTH),
        .AW        (PW)
    ) u_ram (
        .clk   (clk),
        .we    (w_wr_acc),
        .waddr (r_wptr[PW-1:0]),
        .wdata (wdata),
        .raddr (r_rptr[PW-1:0]),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (flush) begin
                r_wptr   <= '0;
                r_rptr   <= '0;
                r_count  <= '0;
                r_rvalid <= 1'b0;
            end else begin
                if (w_wr_acc) r_wptr <= r_wptr + L_ONE;
                if (w_rd_acc) r_rptr <= r_rptr + L_ONE;
                case ({w_wr_acc, w_rd_acc})
                    2'b10:   r_count <= r_count + L_ONE;
                    2'b01:   r_count <= r_count - L_ONE;
                    default: r_count <= r_count;
                endcase
                r_rvalid <= w_rd_acc;
                if (w_rd_acc) r_rdata <= w_ram_rdata;
            end
            // A new error event wins over a coincident clear.
            if (w_ovf_evt)    r_overflow <= 1'b1;
            else if (clr_err) r_overflow <= 1'b0;
            if (w_unf_evt)    r_underflow <= 1'b1;
            else if (clr_err) r_underflow <= 1'b0;
        end
    end

    assign rdata        = (FWFT == FWFT_ON) ? w_ram_rdata : r_rdata;
    assign rvalid       = (FWFT == FWFT_ON) ? !w_empty    : r_rvalid;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= L_AF);
    assign almost_empty = (r_count <= L_AE);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb/tb_sync_fifo_flex.sv - self-checking bench for sync_fifo_flex (standard and FWFT instances)
module tb_sync_fifo_flex;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = DEPTH - 1;
    localparam int AE    = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, clr_err, wr, rd;
    logic [DW-1:0] wdata;

    logic [DW-1:0] rdata, rdata_f;
    logic          rvalid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic          rvalid_f, full_f, empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f;
    logic [3:0]    count, count_f;
    logic [9:0]    w_st, w_st_f;

    assign w_st   = {full, empty, almost_full, almost_empty, overflow, underflow, count};
    assign w_st_f = {full_f, empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f, count_f};

    sync_fifo_flex #(.DATAWIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err), .wr(wr), .wdata(wdata), .rd(rd),
        .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_flex #(.DATAWIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err), .wr(wr), .wdata(wdata), .rd(rd),
        .rdata(rdata_f), .rvalid(rvalid_f), .full(full_f), .empty(empty_f),
        .almost_full(almost_full_f), .almost_empty(almost_empty_f), .count(count_f),
        .overflow(overflow_f), .underflow(underflow_f)
    );

    // Reference model: the FIFO contents as a queue plus the visible read/error state.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rdata;
    bit            m_rvalid, m_ovf, m_unf;
    int            n_vec = 0;
    int            n_err = 0;

    function automatic logic [9:0] exp_st();
        int s;
        s = q.size();
        return {s == DEPTH, s == 0, s >= AF, s <= AE, m_ovf, m_unf, 4'(s)};
    endfunction

    function automatic logic [DW-1:0] head();
        return (q.size() != 0) ? q[0] : '0;
    endfunction

    task automatic cyc(input bit r, input bit f, input bit c, input bit w, input bit rr,
                       input logic [DW-1:0] d);
        bit was_full, was_empty;
        rst = r; flush = f; clr_err = c; wr = w; rd = rr; wdata = d;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (r) begin
            q.delete(); m_rdata = '0; m_rvalid = 0; m_ovf = 0; m_unf = 0;
        end else if (f) begin
            q.delete(); m_rvalid = 0;
            if (c) begin m_ovf = 0; m_unf = 0; end
        end else begin
            m_rvalid = rr && !was_empty;
            if (m_rvalid) m_rdata = q.pop_front();
            if (w && !was_full) q.push_back(d);
            if (w && was_full) m_ovf = 1; else if (c) m_ovf = 0;
            if (rr && was_empty) m_unf = 1; else if (c) m_unf = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 1, 1, 8'hFF);
        n_vec++;
        if (w_st !== 10'b01_01_00_0000) begin
            n_err++; $display("FAIL reset_status got=%b exp=%b", w_st, 10'b01_01_00_0000);
        end
        n_vec++;
        if ({rvalid, rdata} !== 9'h000) begin
            n_err++; $display("FAIL reset_read got=%b/%h exp=0/00", rvalid, rdata);
        end
        n_vec++;
        if (rvalid_f !== 1'b0 || w_st_f !== exp_st()) begin
            n_err++; $display("FAIL reset_fwft got=%b/%b exp=0/%b", rvalid_f, w_st_f, exp_st());
        end
        cyc(0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(0, 0, 0, 1, 0, 8'(i));
            n_vec++;
            if (w_st !== exp_st() || count !== 4'(i)) begin
                n_err++; $display("FAIL fill_status i=%0d got=%b exp=%b", i, w_st, exp_st());
            end
        end
        n_vec++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            n_err++; $display("FAIL fill_full got=%b/%b exp=1/0", full, overflow);
        end
    endtask

    task automatic test_overflow_drain();
        cyc(0, 0, 0, 1, 0, 8'hAA);
        n_vec++;
        if (w_st !== exp_st() || overflow !== 1'b1 || count !== 4'd8) begin
            n_err++; $display("FAIL ovf_status got=%b exp=%b", w_st, exp_st());
        end
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(0, 0, 0, 0, 1, 8'h00);
            n_vec++;
            if (rvalid !== 1'b1 || rdata !== 8'(i) || w_st !== exp_st()) begin
                n_err++; $display("FAIL drain i=%0d got=%b/%h/%b exp=1/%h/%b",
                                  i, rvalid, rdata, w_st, 8'(i), exp_st());
            end
        end
        cyc(0, 0, 0, 0, 0, 8'h00);
        n_vec++;
        if (rvalid !== 1'b0 || empty !== 1'b1 || rdata !== 8'h08) begin
            n_err++; $display("FAIL drain_idle got=%b/%b/%h exp=0/1/08", rvalid, empty, rdata);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            bit w, r;
            w = (i < 16);
            r = (i >= 4);
            cyc(0, 0, 0, w, r, 8'($urandom));
            n_vec++;
            if (w_st !== exp_st() || {rvalid, rdata} !== {m_rvalid, m_rdata}) begin
                n_err++; $display("FAIL b2b i=%0d got=%b/%b/%h exp=%b/%b/%h",
                                  i, w_st, rvalid, rdata, exp_st(), m_rvalid, m_rdata);
            end
            n_vec++;
            if (rvalid_f !== (q.size() != 0) || (q.size() != 0 && rdata_f !== head())) begin
                n_err++; $display("FAIL b2b_fwft i=%0d got=%b/%h exp=%b/%h",
                                  i, rvalid_f, rdata_f, q.size() != 0, head());
            end
            if (i >= 4 && i < 16) begin
                n_vec++;
                if (count !== 4'd4) begin
                    n_err++; $display("FAIL b2b_count i=%0d got=%0d exp=4", i, count);
                end
            end
        end
    endtask

    task automatic test_fwft();
        cyc(0, 0, 0, 1, 0, 8'h5C);
        n_vec++;
        if (rvalid_f !== 1'b1 || rdata_f !== 8'h5C) begin
            n_err++; $display("FAIL fwft_show got=%b/%h exp=1/5c", rvalid_f, rdata_f);
        end
        cyc(0, 0, 0, 0, 0, 8'h00);
        n_vec++;
        if (rvalid_f !== 1'b1 || rdata_f !== 8'h5C || rvalid !== 1'b0) begin
            n_err++; $display("FAIL fwft_hold got=%b/%h std_rvalid=%b exp=1/5c/0", rvalid_f, rdata_f, rvalid);
        end
        cyc(0, 0, 0, 0, 1, 8'h00);
        n_vec++;
        if (empty_f !== 1'b1 || rvalid_f !== 1'b0 || rvalid !== 1'b1 || rdata !== 8'h5C) begin
            n_err++; $display("FAIL fwft_pop got=%b/%b std=%b/%h exp=1/0 std=1/5c",
                              empty_f, rvalid_f, rvalid, rdata);
        end
    endtask

    task automatic test_underflow();
        cyc(0, 0, 1, 0, 0, 8'h00);
        cyc(0, 0, 0, 0, 1, 8'h00);
        n_vec++;
        if (underflow !== 1'b1 || count !== 4'd0 || w_st !== exp_st()) begin
            n_err++; $display("FAIL unf_set got=%b exp=%b", w_st, exp_st());
        end
        cyc(0, 1, 0, 1, 1, 8'h11);
        n_vec++;
        if (underflow !== 1'b1 || empty !== 1'b1 || w_st !== exp_st()) begin
            n_err++; $display("FAIL unf_flush got=%b exp=%b", w_st, exp_st());
        end
        cyc(0, 0, 1, 0, 0, 8'h00);
        n_vec++;
        if (underflow !== 1'b0 || w_st !== exp_st()) begin
            n_err++; $display("FAIL unf_clr got=%b exp=%b", w_st, exp_st());
        end
        cyc(0, 0, 1, 0, 1, 8'h00);
        n_vec++;
        if (underflow !== 1'b1 || underflow_f !== 1'b1) begin
            n_err++; $display("FAIL unf_set_wins got=%b/%b exp=1/1", underflow, underflow_f);
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 8'($urandom));
        cyc(0, 0, 0, 1, 0, 8'h00);
        cyc(0, 0, 0, 0, 1, 8'h00);
        cyc(0, 0, 0, 1, 1, 8'h77);
        cyc(0, 0, 0, 1, 1, 8'h78);
        cyc(0, 0, 0, 1, 0, 8'h79);
        cyc(0, 0, 0, 1, 1, 8'h7A);
        cyc(1, 0, 0, 1, 1, 8'hEE);
        n_vec++;
        if (w_st !== 10'b01_01_00_0000 || {rvalid, rdata} !== 9'h000) begin
            n_err++; $display("FAIL rst_mid got=%b/%b/%h exp=%b/0/00", w_st, rvalid, rdata, 10'b01_01_00_0000);
        end
        cyc(0, 0, 0, 1, 0, 8'h3C);
        cyc(0, 0, 0, 0, 1, 8'h00);
        n_vec++;
        if (rvalid !== 1'b1 || rdata !== 8'h3C || empty !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_new got=%b/%h/%b exp=1/3c/1", rvalid, rdata, empty);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit r, f, c, w, rr;
            r  = ($urandom_range(0, 99) == 0);
            f  = ($urandom_range(0, 99) < 2);
            c  = ($urandom_range(0, 99) < 4);
            w  = ($urandom_range(0, 99) < 55);
            rr = ($urandom_range(0, 99) < 50);
            cyc(r, f, c, w, rr, 8'($urandom));
            n_vec++;
            if (w_st !== exp_st() || w_st_f !== exp_st()) begin
                n_err++; $display("FAIL rand_status i=%0d got=%b/%b exp=%b", i, w_st, w_st_f, exp_st());
            end
            n_vec++;
            if ({rvalid, rdata} !== {m_rvalid, m_rdata}) begin
                n_err++; $display("FAIL rand_read i=%0d got=%b/%h exp=%b/%h", i, rvalid, rdata, m_rvalid, m_rdata);
            end
            n_vec++;
            if (rvalid_f !== (q.size() != 0) || (q.size() != 0 && rdata_f !== head())) begin
                n_err++; $display("FAIL rand_fwft i=%0d got=%b/%h exp=%b/%h",
                                  i, rvalid_f, rdata_f, q.size() != 0, head());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_back_to_back();
        test_fwft();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
